// File: rtl/csi2_pkg.sv
// csi2_pkg
//   Shared definitions for the CSI-2 packet decoder slice:
//   - data-type codes for the short-packet markers and RAW8 payload
//   - decoder state encoding
//   - parity masks for the 6-bit packet-header ECC over D[23:0]
//     (DataID is D[7:0], WC low byte D[15:8], WC high byte D[23:16])
package csi2_pkg;

    localparam logic [5:0] FRAME_START = 6'h00;
    localparam logic [5:0] FRAME_END   = 6'h01;
    localparam logic [5:0] LINE_START  = 6'h02;
    localparam logic [5:0] LINE_END    = 6'h03;
    localparam logic [5:0] RAW8        = 6'h2A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // ECC_MASKS[i] selects the data bits XORed into parity bit P<i>.
    localparam logic [5:0][23:0] ECC_MASKS = {
        24'hEFFC00,   // P5
        24'hDF03F0,   // P4
        24'hB8E38E,   // P3
        24'h749A6D,   // P2
        24'hF2555B,   // P1
        24'hF12CB7    // P0
    };

endpackage

// File: rtl/csi2_header_ecc.sv
// csi2_header_ecc
//   Combinational 6-bit Hamming ECC generator for a CSI-2 packet header.
//   Ports:
//     data [23:0] in  : header bytes 0..2, byte0 bit0 = D0
//     ecc  [5:0]  out : computed parity P5..P0
module csi2_header_ecc
    import csi2_pkg::*;
(
    input  logic [23:0] data,
    output logic [5:0]  ecc
);

    for (genvar i = 0; i < 6; i++) begin : g_parity
        assign ecc[i] = ^(data & ECC_MASKS[i]);
    end

endmodule

// File: rtl/csi2_packet_decoder.sv
// csi2_packet_decoder
//   Parses one CSI-2 packet per HS burst from a 4-lane byte-aligned receiver,
//   checks the header ECC, filters on VC/DT, forwards RAW8 payload words and
//   pulses frame/line markers and error flags. Single clock domain (mipi_clk).
//   Ports:
//     mipi_clk, reset_n        : byte clock, async active-low reset
//     lane_data [31:0]         : lane 0 in [7:0] .. lane 3 in [31:24]
//     lane_valid               : high for the whole burst, one packet per burst
//     mipi_data [31:0]         : payload word, [7:0] is the earliest byte
//     mipi_data_enable         : payload word valid
//     frame_start/frame_end/line_start/line_end : 1-cycle marker pulses
//     header_error, length_error                : 1-cycle error pulses
//     state_dbg [1:0]          : current decoder state (csi2_pkg::state_t)
//
//   Handshake: lane_valid and mipi_data_enable are plain valid strobes with no
//   ready; a word is transferred on every clock edge where its valid is high,
//   and the downstream side must accept one word per cycle.
module csi2_packet_decoder
    import csi2_pkg::*;
#(
    parameter logic [1:0]  VIRTUAL_CHANNEL = 2'd0,
    parameter logic [5:0]  DATA_TYPE       = RAW8,
    parameter logic [15:0] MAX_WORD_COUNT  = 16'd4096
) (
    input  logic        mipi_clk,
    input  logic        reset_n,
    input  logic [31:0] lane_data,
    input  logic        lane_valid,
    output logic [31:0] mipi_data,
    output logic        mipi_data_enable,
    output logic        frame_start,
    output logic        frame_end,
    output logic        line_start,
    output logic        line_end,
    output logic        header_error,
    output logic        length_error,
    output logic [1:0]  state_dbg
);

    state_t      state;
    logic [13:0] words_left;

    // Header fields, only meaningful in the first cycle of a burst.
    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic [5:0]  hdr_ecc_rx;
    logic [5:0]  hdr_ecc_calc;
    logic        ecc_ok;
    logic        vc_match;

    assign hdr_vc     = lane_data[7:6];
    assign hdr_dt     = lane_data[5:0];
    assign hdr_wc     = lane_data[23:8];
    assign hdr_ecc_rx = lane_data[29:24];   // ECC[7:6] are reserved and ignored
    assign ecc_ok     = (hdr_ecc_calc == hdr_ecc_rx);
    assign vc_match   = (hdr_vc == VIRTUAL_CHANNEL);
    assign state_dbg  = state;

    csi2_header_ecc u_header_ecc (
        .data (lane_data[23:0]),
        .ecc  (hdr_ecc_calc)
    );

    always_ff @(posedge mipi_clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            words_left       <= '0;
            mipi_data        <= '0;
            mipi_data_enable <= 1'b0;
            frame_start      <= 1'b0;
            frame_end        <= 1'b0;
            line_start       <= 1'b0;
            line_end         <= 1'b0;
            header_error     <= 1'b0;
            length_error     <= 1'b0;
        end else begin
            mipi_data_enable <= 1'b0;
            frame_start      <= 1'b0;
            frame_end        <= 1'b0;
            line_start       <= 1'b0;
            line_end         <= 1'b0;
            header_error     <= 1'b0;
            length_error     <= 1'b0;

            case (state)
                IDLE: begin
                    if (lane_valid) begin
                        if (!ecc_ok) begin
                            header_error <= 1'b1;
                            state        <= DRAIN;
                        end else if (hdr_dt <= 6'h0F) begin
                            if (vc_match) begin
                                case (hdr_dt)
                                    FRAME_START: frame_start <= 1'b1;
                                    FRAME_END:   frame_end   <= 1'b1;
                                    LINE_START:  line_start  <= 1'b1;
                                    LINE_END:    line_end    <= 1'b1;
                                    default:     ;
                                endcase
                            end
                            state <= DRAIN;
                        end else if (vc_match && hdr_dt == DATA_TYPE) begin
                            if (hdr_wc > MAX_WORD_COUNT) begin
                                length_error <= 1'b1;
                                state        <= DRAIN;
                            end else begin
                                // Partial trailing word: flag it, drop its bytes.
                                if (hdr_wc[1:0] != 2'b00)
                                    length_error <= 1'b1;
                                // With no whole word to forward, skip PAYLOAD so a
                                // burst following a one-cycle gap is not missed.
                                if (hdr_wc[15:2] != 14'd0) begin
                                    words_left <= hdr_wc[15:2];
                                    state      <= PAYLOAD;
                                end else begin
                                    state      <= DRAIN;
                                end
                            end
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end

                PAYLOAD: begin
                    // words_left is always >= 1 here, so it never wraps.
                    if (lane_valid) begin
                        mipi_data        <= lane_data;
                        mipi_data_enable <= 1'b1;
                        words_left       <= words_left - 14'd1;
                        if (words_left == 14'd1)
                            state <= DRAIN;
                    end else begin
                        length_error <= 1'b1;
                        words_left   <= '0;
                        state        <= IDLE;
                    end
                end

                DRAIN: begin
                    if (!lane_valid)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csi2_packet_decoder.sv
// tb_csi2_packet_decoder
//   Drives CSI-2 bursts into csi2_packet_decoder and checks every output cycle
//   against a per-cycle expectation table and a payload queue filled by a
//   packet-level reference model.
module tb_csi2_packet_decoder;
    import csi2_pkg::*;

    localparam logic [1:0]  VC_P  = 2'd0;
    localparam logic [5:0]  DT_P  = 6'h2A;
    localparam logic [15:0] MAX_P = 16'd4096;
    localparam int          DEPTH = 8192;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        reset_n;
    logic [31:0] lane_data;
    logic        lane_valid;
    logic [31:0] mipi_data;
    logic        mipi_data_enable;
    logic        frame_start, frame_end, line_start, line_end;
    logic        header_error, length_error;
    logic [1:0]  state_dbg;

    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csi2_packet_decoder #(
        .VIRTUAL_CHANNEL (VC_P),
        .DATA_TYPE       (DT_P),
        .MAX_WORD_COUNT  (MAX_P)
    ) dut (
        .mipi_clk         (clk),
        .reset_n          (reset_n),
        .lane_data        (lane_data),
        .lane_valid       (lane_valid),
        .mipi_data        (mipi_data),
        .mipi_data_enable (mipi_data_enable),
        .frame_start      (frame_start),
        .frame_end        (frame_end),
        .line_start       (line_start),
        .line_end         (line_end),
        .header_error     (header_error),
        .length_error     (length_error),
        .state_dbg        (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic        mon_on   = 1'b1;
    logic [31:0] exp_q[$];
    logic [31:0] burst_q[$];
    // bit order: {header_error, length_error, line_end, line_start, frame_end, frame_start}
    logic [5:0]  exp_pulse [DEPTH];
    logic        exp_en    [DEPTH];
    logic [5:0]  dt_pool   [10] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h05,
                                    6'h2A, 6'h2A, 6'h2A, 6'h2B, 6'h12};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Hamming column code of each data bit (which parity bits it feeds).
    function automatic logic [5:0] col_code(input int i);
        case (i)
            0: return 6'h07;  1: return 6'h0B;  2: return 6'h0D;  3: return 6'h0E;
            4: return 6'h13;  5: return 6'h15;  6: return 6'h16;  7: return 6'h19;
            8: return 6'h1A;  9: return 6'h1C; 10: return 6'h23; 11: return 6'h25;
           12: return 6'h26; 13: return 6'h29; 14: return 6'h2A; 15: return 6'h2C;
           16: return 6'h31; 17: return 6'h32; 18: return 6'h34; 19: return 6'h38;
           20: return 6'h1F; 21: return 6'h2F; 22: return 6'h37; 23: return 6'h3B;
            default: return 6'h00;
        endcase
    endfunction

    function automatic logic [5:0] tb_ecc(input logic [23:0] d);
        logic [5:0] e;
        e = 6'h00;
        for (int i = 0; i < 24; i++)
            if (d[i]) e = e ^ col_code(i);
        return e;
    endfunction

    function automatic logic [31:0] mk_hdr(input logic [1:0] vc, input logic [5:0] dt,
                                           input logic [15:0] wc, input int flip);
        logic [23:0] d;
        logic [31:0] w;
        d = {wc, vc, dt};
        w = {2'($urandom_range(0, 3)), tb_ecc(d), d};
        if (flip >= 0) w[flip] = ~w[flip];
        return w;
    endfunction

    task automatic set_pulse(input int idx, input int b);
        if (idx < DEPTH) exp_pulse[idx][b] = 1'b1;
    endtask

    // Expected outputs for the burst in burst_q whose header is sampled at edge h.
    task automatic model(input int h);
        logic [31:0] hdr;
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        int          len;
        int          n;
        hdr = burst_q[0];
        vc  = hdr[7:6];
        dt  = hdr[5:0];
        wc  = hdr[23:8];
        len = burst_q.size();
        if (tb_ecc(hdr[23:0]) != hdr[29:24]) begin
            set_pulse(h, 5);
        end else if (dt < 16) begin
            if (vc == VC_P && dt < 4) set_pulse(h, int'(dt));
        end else if (vc == VC_P && dt == DT_P) begin
            if (wc > MAX_P) begin
                set_pulse(h, 4);
            end else begin
                if (wc % 4 != 0) set_pulse(h, 4);
                n = int'(wc) / 4;
                for (int k = 1; k <= n; k++) begin
                    if (k < len) begin
                        if (h + k < DEPTH) exp_en[h + k] = 1'b1;
                        exp_q.push_back(burst_q[k]);
                    end else begin
                        set_pulse(h + k, 4);
                        break;
                    end
                end
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_on && cyc < DEPTH) begin
            check("pulses", 32'({header_error, length_error, line_end, line_start,
                                 frame_end, frame_start}), 32'(exp_pulse[cyc]));
            check("enable", 32'(mipi_data_enable), 32'(exp_en[cyc]));
            if (exp_en[cyc] && exp_q.size() > 0) begin
                logic [31:0] w;
                w = exp_q.pop_front();
                if (mipi_data_enable) check("data", mipi_data, w);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_burst();
        int h;
        @(posedge clk); #1;
        h = cyc + 1;
        model(h);
        foreach (burst_q[i]) begin
            lane_valid = 1'b1;
            lane_data  = burst_q[i];
            @(posedge clk); #1;
        end
        lane_valid = 1'b0;
        lane_data  = $urandom;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic burst(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                         input int flip, input int npay);
        burst_q.delete();
        burst_q.push_back(mk_hdr(vc, dt, wc, flip));
        for (int i = 0; i < npay; i++) burst_q.push_back($urandom);
        send_burst();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_enable"}, 32'(mipi_data_enable), 32'd0);
        check({tag, "_data"}, mipi_data, 32'd0);
        check({tag, "_pulses"}, 32'({header_error, length_error, line_end, line_start,
                                     frame_end, frame_start}), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            exp_pulse[i] = '0;
            exp_en[i]    = 1'b0;
        end
        reset_n    = 1'b0;
        lane_valid = 1'b0;
        lane_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        reset_n = 1'b1;

        // Frame start short packet.
        burst(2'd0, FRAME_START, 16'd0, -1, 0);
        // RAW8 WC=8 with known bytes and a CRC word.
        burst_q.delete();
        burst_q.push_back(mk_hdr(2'd0, RAW8, 16'd8, -1));
        burst_q.push_back(32'h03020100);
        burst_q.push_back(32'h07060504);
        burst_q.push_back(32'hDEADBEEF);
        send_burst();
        // ECC error (D5 flipped), then a clean packet.
        burst(2'd0, RAW8, 16'd8, 5, 3);
        burst(2'd0, RAW8, 16'd4, -1, 2);
        // ECC[7:6] flipped is not an error; an ECC bit flipped is.
        burst(2'd0, LINE_START, 16'd0, 31, 0);
        burst(2'd0, LINE_END, 16'd0, 26, 0);
        // Filtering.
        burst(2'd1, RAW8, 16'd8, -1, 3);
        burst(2'd0, 6'h2B, 16'd8, -1, 3);
        burst(2'd3, FRAME_END, 16'd0, -1, 0);
        burst(2'd0, FRAME_END, 16'd0, -1, 1);
        // Truncation and bad WC.
        burst(2'd0, RAW8, 16'd16, -1, 2);
        burst(2'd0, RAW8, 16'd6, -1, 2);
        burst(2'd0, RAW8, 16'd2, -1, 1);
        burst(2'd0, RAW8, 16'd0, -1, 1);
        burst(2'd0, RAW8, 16'd4100, -1, 2);
        burst(2'd0, RAW8, 16'd4096, -1, 0);
        burst(2'd0, RAW8, 16'd12, -1, 3);

        // Randomized bursts.
        for (int t = 0; t < 200; t++) begin
            logic [1:0]  vc;
            logic [5:0]  dt;
            logic [15:0] wc;
            int          flip;
            int          n;
            int          npay;
            vc = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            dt = dt_pool[$urandom_range(0, 9)];
            case ($urandom_range(0, 7))
                0:       wc = 16'($urandom_range(0, 15));
                1:       wc = 16'($urandom_range(4097, 65535));
                default: wc = 16'(4 * $urandom_range(1, 8));
            endcase
            flip = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : -1;
            n    = (wc <= 16'd64) ? int'(wc) / 4 : 0;
            npay = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n)
                                               : n + $urandom_range(0, 2);
            burst(vc, dt, wc, flip, npay);
        end

        // Asynchronous reset in the middle of a payload.
        repeat (2) @(posedge clk);
        #1;
        mon_on     = 1'b0;
        lane_valid = 1'b1;
        lane_data  = mk_hdr(2'd0, RAW8, 16'd32, -1);
        repeat (3) begin
            @(posedge clk); #1;
            lane_data = $urandom;
        end
        @(posedge clk); #3;
        check("pre_reset_enable", 32'(mipi_data_enable), 32'd1);
        reset_n = 1'b0;
        #1;
        check_quiet("mid_payload_reset");
        lane_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_quiet("post_reset");
        mon_on = 1'b1;
        burst(2'd0, FRAME_START, 16'd0, -1, 0);
        burst(2'd0, RAW8, 16'd8, -1, 3);
        repeat (4) @(posedge clk);
        #1;

        check("leftover_words", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csi2_packet_decoder.md
# csi2_packet_decoder

Parses CSI-2 packets from the 4-lane, byte-aligned D-PHY receiver and emits RAW8 payload words to the SDRAM arbiter's `mipi_data`/`mipi_data_enable` input. It sits directly upstream of the arbiter in the `mipi_clk` domain. It validates the packet-header ECC, filters on virtual channel and data type, strips the CRC footer, and flags frame/line markers and errors.

## Interface
- `VIRTUAL_CHANNEL`, default 2'd0: the only VC that is accepted.
- `DATA_TYPE`, default 6'h2A: the only long-packet data type that is forwarded (RAW8).
- `MAX_WORD_COUNT`, default 16'd4096: long packets with a larger WC are rejected.
- `mipi_clk` in 1: byte clock. This is the block's single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `lane_data` in 8×[0:3]: one byte per lane. Lane 0 carries the lowest byte.
- `lane_valid` in 1: high during an HS burst once the lanes are aligned. Each burst carries exactly one packet.
- `mipi_data` out 8×[0:3]: payload word. `mipi_data[0]` is the earliest byte.
- `mipi_data_enable` out 1: payload word valid.
- `frame_start`, `frame_end`, `line_start`, `line_end` out 1 each: one-cycle pulses, raised for matching-VC short packets only.
- `header_error` out 1: one-cycle pulse on an ECC mismatch.
- `length_error` out 1: one-cycle pulse on WC > MAX_WORD_COUNT, on WC not a multiple of 4, or on a burst that ends early.

## Operation
- Header bytes: the header is the first `lane_valid` cycle after IDLE.
  - Byte 0 is the DataID: VC = [7:6], DT = [5:0].
  - Bytes 1 and 2 are WC, low byte then high byte.
  - Byte 3 is the ECC.
- ECC check: compute the 6-bit Hamming ECC over D[23:0] per the CSI-2 table, with byte0 bit0 = D0. Compare it with ECC[5:0] and ignore ECC[7:6]. The block detects errors only; it does not correct them.
- State IDLE: on `lane_valid` = 1, evaluate the header in that same cycle.
  - ECC bad → pulse `header_error`, go to DRAIN.
  - Otherwise, DT ≤ 6'h0F (short packet) and VC matches → pulse the marker for DT 0/1/2/3. Other short DTs raise no pulse. Go to DRAIN.
  - Otherwise, long packet with VC == VIRTUAL_CHANNEL and DT == DATA_TYPE:
    - If WC ≤ MAX_WORD_COUNT and WC ≠ 0 → load `words_left` = WC[15:2] and go to PAYLOAD.
    - If WC[1:0] ≠ 0, also pulse `length_error`; the remainder bytes are discarded.
    - If WC > MAX_WORD_COUNT → pulse `length_error`, go to DRAIN.
  - Any other long packet → DRAIN silently.
- State PAYLOAD: each cycle with `lane_valid` = 1 forwards `lane_data` and decrements `words_left`. When the last word is forwarded, go to DRAIN.
  - `lane_valid` = 0 while `words_left` ≠ 0 → pulse `length_error`, go to IDLE.
  - If WC[1:0] ≠ 0 and `words_left` == 0 at entry, go directly to DRAIN.
- State DRAIN: discard the CRC footer and any trailing bytes. Go to IDLE when `lane_valid` = 0.
- The CRC is not checked.
- Counter width: `words_left` is 14 bits. It is never decremented below 0.

## Timing
- Reset values: all outputs are 0, `mipi_data` is all-zero, and the state is IDLE. The reset takes effect immediately and asynchronously, including mid-payload. No partial pulse or word is emitted after `reset_n` rises.
- All outputs are registered.
- Header at input cycle N:
  - Markers and errors are visible at N+1.
  - The first payload word is input at N+1 and output at N+2.
  - Payload latency is 1 cycle, with no bubbles: `mipi_data_enable` mirrors `lane_valid` during PAYLOAD, delayed by one cycle.
- Minimum gap: `lane_valid` must be low for ≥1 cycle between bursts. A burst starting in the cycle after DRAIN's exit is handled as a fresh header.
- Simultaneous events: if `lane_valid` falls in the same cycle the last word would have arrived, the packet is truncated. In that case `length_error` = 1 and that word is not emitted.
- There is no backpressure. The downstream FIFO must absorb one word per cycle.

## Structure
- Package `csi2_pkg` holds:
  - DT constants (FRAME_START = 6'h00, FRAME_END = 6'h01, LINE_START = 6'h02, LINE_END = 6'h03, RAW8 = 6'h2A).
  - The state enum {IDLE, PAYLOAD, DRAIN}.
  - The six 24-bit ECC parity masks.
- Sub-module `csi2_header_ecc` is combinational. It takes 24 bits in and produces the 6-bit ECC, and is reused by a future ECC-correcting stage.

## Test plan
- Frame start: header {00,00,00,ECC(000000)} for one cycle → `frame_start` = 1 for exactly one cycle at N+1; no `mipi_data_enable`.
- RAW8 WC=8: header {2A,08,00,ECC}, then payload words 03020100 and 07060504, then CRC word → two enables at N+2 and N+3 with those exact bytes; CRC never forwarded.
- ECC error: RAW8 header with bit D5 flipped → `header_error` pulse; zero payload words emitted; a following valid burst decodes normally.
- Filtering: VC=1 RAW8 packet, then DT=2B packet → no enables, no pulses.
- Truncation and bad WC:
  - WC=16 with `lane_valid` dropped after 2 payload words → 2 enables, then a `length_error` pulse.
  - WC=6 → 1 word emitted and a `length_error` pulse.
- Reset: assert `reset_n` = 0 mid-PAYLOAD → outputs 0 within the same cycle; after release, the next burst is parsed as a header.
